// File: rtl/sin_lut_arb_pkg.sv
// Shared definitions for the sin/cos LUT arbiter: default LUT latency,
// tag-width helper and the {valid, id} tag carried alongside each LUT access.
package sin_lut_arb_pkg;

    localparam int LUT_LAT_DEFAULT = 4;
    localparam int MAX_NREQ        = 16;
    localparam int TAG_ID_W        = $clog2(MAX_NREQ);

    // Width of a requester index; never below one bit so ports stay legal.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // One delay-line entry: whether the slot carries a live access and for whom.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/sin_lut_arb_rr.sv
// Two-grant round-robin picker: scans the request vector upward from ptr,
// returns the first two pending requesters and the pointer that follows them.
module sin_lut_arb_rr
    import sin_lut_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            g0_valid_o,
    output logic [IDW-1:0]  g0_idx_o,
    output logic            g1_valid_o,
    output logic [IDW-1:0]  g1_idx_o,
    output logic [IDW-1:0]  next_ptr_o
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    logic [IDW:0] slot;

    // Walk every slot once starting at ptr; the first hit goes to port 0, the second to port 1.
    always_comb begin
        g0_valid_o = 1'b0;
        g0_idx_o   = '0;
        g1_valid_o = 1'b0;
        g1_idx_o   = '0;
        slot       = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot = {1'b0, ptr_i} + (IDW+1)'(k);
            if (slot >= NREQ_W) begin
                slot = slot - NREQ_W;
            end
            if (req_i[slot[IDW-1:0]]) begin
                if (!g0_valid_o) begin
                    g0_valid_o = 1'b1;
                    g0_idx_o   = slot[IDW-1:0];
                end else if (!g1_valid_o) begin
                    g1_valid_o = 1'b1;
                    g1_idx_o   = slot[IDW-1:0];
                end
            end
        end
    end

    // Pointer moves just past the last winner so the next scan starts with the next requester in line.
    always_comb begin
        next_ptr_o = ptr_i;
        if (g1_valid_o) begin
            next_ptr_o = (g1_idx_o == LAST_IDX) ? '0 : g1_idx_o + IDW'(1);
        end else if (g0_valid_o) begin
            next_ptr_o = (g0_idx_o == LAST_IDX) ? '0 : g0_idx_o + IDW'(1);
        end
    end

endmodule

// File: rtl/sin_lut_arbiter.sv
// Shares one dual-port sin/cos LUT among NREQ requesters: up to two grants per
// cycle, registered LUT arguments, and per-port tag delay lines that return
// each result with the id of the requester that issued it.
module sin_lut_arbiter
    import sin_lut_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int LUT_LAT = LUT_LAT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_arg,
    input  logic [NREQ-1:0]             req_mode,
    output logic                        lut_clkena,
    output logic [WIDTH-1:0]            lut_arg0,
    output logic [WIDTH-1:0]            lut_arg1,
    output logic                        lut_mode0,
    output logic                        lut_mode1,
    input  logic [WIDTH-1:0]            lut_func0,
    input  logic [WIDTH-1:0]            lut_func1,
    output logic                        rsp0_valid,
    output logic                        rsp1_valid,
    output logic [id_width(NREQ)-1:0]   rsp0_id,
    output logic [id_width(NREQ)-1:0]   rsp1_id,
    output logic [WIDTH-1:0]            rsp0_data,
    output logic [WIDTH-1:0]            rsp1_data
);

    localparam int IDW = id_width(NREQ);

    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic             g0_valid;
    logic             g1_valid;
    logic [IDW-1:0]   g0_idx;
    logic [IDW-1:0]   g1_idx;
    logic [IDW-1:0]   next_ptr;
    logic             run;
    logic [WIDTH-1:0] arg0_q;
    logic [WIDTH-1:0] arg1_q;
    logic             mode0_q;
    logic             mode1_q;
    tag_t             new_tag0;
    tag_t             new_tag1;
    tag_t             tag0_q [LUT_LAT+1];
    tag_t             tag1_q [LUT_LAT+1];
    logic             unused_tag_hi;

    sin_lut_arb_rr #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_i      (req_valid),
        .ptr_i      (ptr_q),
        .g0_valid_o (g0_valid),
        .g0_idx_o   (g0_idx),
        .g1_valid_o (g1_valid),
        .g1_idx_o   (g1_idx),
        .next_ptr_o (next_ptr)
    );

    // Grants only count on enabled cycles outside reset; ready is withheld otherwise.
    assign run        = enable & ~reset;
    assign lut_clkena = enable;

    // Decode the two winning indices into the per-requester ready vector.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (run && ((g0_valid && g0_idx == IDW'(i)) || (g1_valid && g1_idx == IDW'(i)))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Next pointer only advances on enabled cycles; the picker already holds it when nobody wins.
    always_comb begin
        ptr_d = ptr_q;
        if (run) begin
            ptr_d = next_ptr;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Build the stage-1 tags from this cycle's winners, widening the id into the shared tag field.
    always_comb begin
        new_tag0                = '0;
        new_tag1                = '0;
        new_tag0.valid          = g0_valid;
        new_tag0.id[IDW-1:0]    = g0_idx;
        new_tag1.valid          = g1_valid;
        new_tag1.id[IDW-1:0]    = g1_idx;
    end

    // LUT argument registers: a granted port loads its requester's operands, an idle port loads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            arg0_q  <= '0;
            arg1_q  <= '0;
            mode0_q <= 1'b0;
            mode1_q <= 1'b0;
        end else if (enable) begin
            arg0_q  <= g0_valid ? req_arg[g0_idx]  : '0;
            mode0_q <= g0_valid ? req_mode[g0_idx] : 1'b0;
            arg1_q  <= g1_valid ? req_arg[g1_idx]  : '0;
            mode1_q <= g1_valid ? req_mode[g1_idx] : 1'b0;
        end
    end

    assign lut_arg0  = arg0_q;
    assign lut_arg1  = arg1_q;
    assign lut_mode0 = mode0_q;
    assign lut_mode1 = mode1_q;

    // Tag delay lines track the LUT pipeline, so they advance only when the LUT does.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= LUT_LAT; s++) begin
                tag0_q[s] <= '0;
                tag1_q[s] <= '0;
            end
        end else if (enable) begin
            tag0_q[0] <= new_tag0;
            tag1_q[0] <= new_tag1;
            for (int s = 1; s <= LUT_LAT; s++) begin
                tag0_q[s] <= tag0_q[s-1];
                tag1_q[s] <= tag1_q[s-1];
            end
        end
    end

    assign rsp0_valid = tag0_q[LUT_LAT].valid & enable;
    assign rsp1_valid = tag1_q[LUT_LAT].valid & enable;
    assign rsp0_id    = tag0_q[LUT_LAT].id[IDW-1:0];
    assign rsp1_id    = tag1_q[LUT_LAT].id[IDW-1:0];
    assign rsp0_data  = lut_func0;
    assign rsp1_data  = lut_func1;

    // The tag id field is sized for the largest arbiter; its upper bits stay zero here.
    assign unused_tag_hi = ^{tag0_q[LUT_LAT].id, tag1_q[LUT_LAT].id};

endmodule

// File: tb/tb_sin_lut_arbiter.sv
// Directed bench for sin_lut_arbiter with a behavioural LUT and a per-port
// scoreboard: each issued vector pushes its expected responses, and a monitor
// pops and compares whenever a response port presents a result.
module tb_sin_lut_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
        int               due;
    } expItem_t;

    logic                       clk;
    logic                       reset;
    logic                       enable;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][WIDTH-1:0] req_arg;
    logic [NREQ-1:0]            req_mode;
    logic                       lut_clkena;
    logic [WIDTH-1:0]           lut_arg0;
    logic [WIDTH-1:0]           lut_arg1;
    logic                       lut_mode0;
    logic                       lut_mode1;
    logic [WIDTH-1:0]           lut_func0;
    logic [WIDTH-1:0]           lut_func1;
    logic                       rsp0_valid;
    logic                       rsp1_valid;
    logic [1:0]                 rsp0_id;
    logic [1:0]                 rsp1_id;
    logic [WIDTH-1:0]           rsp0_data;
    logic [WIDTH-1:0]           rsp1_data;

    int       checks = 0;
    int       errors = 0;
    int       enCnt  = 0;
    logic     rstSeen = 1'b0;
    expItem_t q0[$];
    expItem_t q1[$];
    logic [WIDTH-1:0] pipe0 [LAT];
    logic [WIDTH-1:0] pipe1 [LAT];

    sin_lut_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .LUT_LAT (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_arg    (req_arg),
        .req_mode   (req_mode),
        .lut_clkena (lut_clkena),
        .lut_arg0   (lut_arg0),
        .lut_arg1   (lut_arg1),
        .lut_mode0  (lut_mode0),
        .lut_mode1  (lut_mode1),
        .lut_func0  (lut_func0),
        .lut_func1  (lut_func1),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp0_id    (rsp0_id),
        .rsp1_id    (rsp1_id),
        .rsp0_data  (rsp0_data),
        .rsp1_data  (rsp1_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in LUT contents: sin(pi/2) is full scale, other entries are easy-to-predict tokens.
    function automatic logic [WIDTH-1:0] lutFn(input logic [WIDTH-1:0] a, input logic m);
        if (!m && a == 16'h4000) return 16'h7FFF;
        if (!m && a == 16'h0000) return 16'h0000;
        return m ? (a ^ 16'hC3C3) : (a + 16'h0101);
    endfunction

    function automatic logic [NREQ-1:0][WIDTH-1:0] mkArgs(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                                                         input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a3);
        logic [NREQ-1:0][WIDTH-1:0] r;
        r[0] = a0;
        r[1] = a1;
        r[2] = a2;
        r[3] = a3;
        return r;
    endfunction

    // Behavioural LUT: LAT-deep pipeline that advances only on clock enable.
    always @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < LAT; s++) begin
                pipe0[s] <= '0;
                pipe1[s] <= '0;
            end
        end else if (lut_clkena) begin
            pipe0[0] <= lutFn(lut_arg0, lut_mode0);
            pipe1[0] <= lutFn(lut_arg1, lut_mode1);
            for (int s = 1; s < LAT; s++) begin
                pipe0[s] <= pipe0[s-1];
                pipe1[s] <= pipe1[s-1];
            end
        end
    end

    assign lut_func0 = pipe0[LAT-1];
    assign lut_func1 = pipe1[LAT-1];

    // Count enabled cycles so expected responses can be timed across enable gaps.
    always @(posedge clk) begin
        rstSeen <= reset;
        if (!reset && enable) enCnt <= enCnt + 1;
    end

    task automatic checkOutput(input int port, input logic v, input logic [1:0] id, input logic [WIDTH-1:0] data);
        expItem_t item;
        bit       have;
        have = 1'b0;
        if (port == 0 && q0.size() > 0) begin
            have = 1'b1;
            item = q0[0];
        end else if (port == 1 && q1.size() > 0) begin
            have = 1'b1;
            item = q1[0];
        end
        if (v) begin
            checks++;
            if (!have) begin
                errors++;
                $display("[TB] FAIL rsp%0d_unexpected got valid id %0d want no response", port, id);
            end else begin
                if (port == 0) void'(q0.pop_front());
                else           void'(q1.pop_front());
                checks++;
                if (int'(id) != item.id) begin
                    errors++;
                    $display("[TB] FAIL rsp%0d_id got %0d want %0d", port, id, item.id);
                end
                checks++;
                if (data !== item.data) begin
                    errors++;
                    $display("[TB] FAIL rsp%0d_data got %h want %h", port, data, item.data);
                end
                checks++;
                if (enCnt != item.due) begin
                    errors++;
                    $display("[TB] FAIL rsp%0d_latency got cycle %0d want %0d", port, enCnt, item.due);
                end
            end
        end else if (have && item.due <= enCnt) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp%0d_missing got no response want id %0d at cycle %0d", port, item.id, item.due);
            if (port == 0) void'(q0.pop_front());
            else           void'(q1.pop_front());
        end
    endtask

    // Monitor: reset and idle behaviour, then scoreboard both response ports on enabled cycles.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("[TB] FAIL reset_ready got %b want 0000", req_ready);
            end
            if (rstSeen) begin
                checks++;
                if ({rsp0_valid, rsp1_valid, rsp0_id, rsp1_id, lut_arg0, lut_arg1, lut_mode0, lut_mode1} !== '0) begin
                    errors++;
                    $display("[TB] FAIL reset_outputs got v%b%b id%0d/%0d arg %h/%h mode %b%b want all 0",
                             rsp0_valid, rsp1_valid, rsp0_id, rsp1_id, lut_arg0, lut_arg1, lut_mode0, lut_mode1);
                end
            end
            q0.delete();
            q1.delete();
        end else if (!enable) begin
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL disabled_rsp got %b%b want 00", rsp0_valid, rsp1_valid);
            end
        end else begin
            checkOutput(0, rsp0_valid, rsp0_id, rsp0_data);
            checkOutput(1, rsp1_valid, rsp1_id, rsp1_data);
        end
    end

    // Drive one cycle of inputs, push the hand-predicted grants, and check ready / clock enable.
    task automatic applyStimulus(input logic rst, input logic en, input logic [NREQ-1:0] valid,
                                 input logic [NREQ-1:0][WIDTH-1:0] args, input logic [NREQ-1:0] modes,
                                 input int g0, input int g1);
        logic [NREQ-1:0] expReady;
        expItem_t        item;
        @(posedge clk);
        #1;
        reset     = rst;
        enable    = en;
        req_valid = valid;
        req_arg   = args;
        req_mode  = modes;
        expReady  = '0;
        if (g0 >= 0) begin
            expReady[g0] = 1'b1;
            item.id   = g0;
            item.data = lutFn(args[g0], modes[g0]);
            item.due  = enCnt + LAT + 1;
            q0.push_back(item);
        end
        if (g1 >= 0) begin
            expReady[g1] = 1'b1;
            item.id   = g1;
            item.data = lutFn(args[g1], modes[g1]);
            item.due  = enCnt + LAT + 1;
            q1.push_back(item);
        end
        #2;
        checks++;
        if (req_ready !== expReady) begin
            errors++;
            $display("[TB] FAIL req_ready got %b want %b", req_ready, expReady);
        end
        checks++;
        if (lut_clkena !== en) begin
            errors++;
            $display("[TB] FAIL lut_clkena got %b want %b", lut_clkena, en);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 4'b0000, mkArgs(16'h0, 16'h0, 16'h0, 16'h0), 4'b0000, -1, -1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        req_valid = '0;
        req_arg   = '0;
        req_mode  = '0;

        $display("[TB] reset with all requests pending");
        repeat (3) applyStimulus(1'b1, 1'b1, 4'b1111, mkArgs(16'h1, 16'h2, 16'h3, 16'h4), 4'b0000, -1, -1);
        idle(1);

        $display("[TB] all four requesters: grants alternate (0,1),(2,3)");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b1, 4'b1111,
                          mkArgs(16'((c + 1) * 16'h1000 + 16'h0011), 16'((c + 1) * 16'h1000 + 16'h0111),
                                 16'((c + 1) * 16'h1000 + 16'h0211), 16'((c + 1) * 16'h1000 + 16'h0311)),
                          4'b1010, (c % 2 == 0) ? 0 : 2, (c % 2 == 0) ? 1 : 3);
        end

        $display("[TB] pointer wrap: 1 and 3 pending from ptr 2");
        applyStimulus(1'b0, 1'b1, 4'b0011, mkArgs(16'h0A00, 16'h0A01, 16'h0, 16'h0), 4'b0001, 0, 1);
        applyStimulus(1'b0, 1'b1, 4'b1010, mkArgs(16'h0, 16'h0B01, 16'h0, 16'h0B03), 4'b1000, 3, 1);
        applyStimulus(1'b0, 1'b1, 4'b1010, mkArgs(16'h0, 16'h0C01, 16'h0, 16'h0C03), 4'b0010, 3, 1);
        applyStimulus(1'b0, 1'b1, 4'b0111, mkArgs(16'h0D00, 16'h0D01, 16'h0D02, 16'h0), 4'b0000, 2, 0);

        $display("[TB] single requester 2, sin(pi/2)");
        applyStimulus(1'b0, 1'b1, 4'b0100, mkArgs(16'h0, 16'h0, 16'h4000, 16'h0), 4'b0000, 2, -1);
        idle(7);

        $display("[TB] enable gap of 3 cycles two cycles after an accept");
        applyStimulus(1'b0, 1'b1, 4'b0010, mkArgs(16'h0, 16'h1234, 16'h0, 16'h0), 4'b0010, 1, -1);
        idle(1);
        repeat (3) applyStimulus(1'b0, 1'b0, 4'b1111, mkArgs(16'h5, 16'h6, 16'h7, 16'h8), 4'b0000, -1, -1);
        idle(8);

        $display("[TB] reset with six results in flight");
        applyStimulus(1'b0, 1'b1, 4'b1111, mkArgs(16'h2000, 16'h2001, 16'h2002, 16'h2003), 4'b0000, 2, 3);
        applyStimulus(1'b0, 1'b1, 4'b1111, mkArgs(16'h2100, 16'h2101, 16'h2102, 16'h2103), 4'b0000, 0, 1);
        applyStimulus(1'b0, 1'b1, 4'b1111, mkArgs(16'h2200, 16'h2201, 16'h2202, 16'h2203), 4'b0000, 2, 3);
        repeat (2) applyStimulus(1'b1, 1'b1, 4'b1111, mkArgs(16'h9, 16'h9, 16'h9, 16'h9), 4'b0000, -1, -1);
        idle(7);
        applyStimulus(1'b0, 1'b1, 4'b1111, mkArgs(16'h3000, 16'h3001, 16'h3002, 16'h3003), 4'b0110, 0, 1);
        idle(7);

        @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("[TB] FAIL port0_drain got %0d outstanding want 0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL port1_drain got %0d outstanding want 0", q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
